// File: rtl/alu_result_stage.sv
// ============================================================================
// alu_result_stage
// ----------------------------------------------------------------------------
// Execute-to-writeback stage that sits directly behind the 32-bit ALU.
//
// Each ALU result is captured into a 2-entry skid buffer, together with:
//   - its flags {N,Z,C,V}
//   - the ALUop that produced it
//   - its destination register index
// The buffer uses a valid/ready handshake on both sides. The head entry
// drives the register-file write port.
//
// When the head entry is committed (popped), the stage also updates:
//   - the architectural {N,Z,C,V} flag register
//   - a saturating counter of add/sub overflow events
//
// Optional feature (macro ALU_RESULT_OVF_TRAP_EN):
//   When the macro is defined, committing an add/sub entry with V=1 does
//   two things:
//     - raises a one-cycle registered trap pulse
//     - suppresses that entry's register write
//   When the macro is undefined, trap is tied low and overflowing results
//   are written normally.
//
// Ports:
//   clk          in   single clock, rising edge
//   resetn       in   synchronous reset, active-low
//   in_valid     in   upstream has an ALU result this cycle
//   in_ready     out  stage can accept this cycle
//   in_result    in   ALU result                  [DATA_WIDTH]
//   in_overflow  in   ALU overflow (V)
//   in_carryout  in   ALU carry-out (C)
//   in_zero      in   ALU zero (Z)
//   in_aluop     in   ALUop that produced the result  [3]
//   in_dest      in   destination register index  [REG_ADDR_W]
//   out_valid    out  head entry valid
//   out_ready    in   writeback consumes the head entry
//   out_wen      out  register-file write enable for the head entry
//   out_dest     out  head destination index      [REG_ADDR_W]
//   out_wdata    out  head result                 [DATA_WIDTH]
//   flags        out  committed {N,Z,C,V}
//   flag_clr     in   clear committed flags (wins over a same-cycle pop)
//   ovf_count    out  committed add/sub overflow events, saturating [CNT_W]
//   trap         out  overflow trap pulse (0 unless ALU_RESULT_OVF_TRAP_EN)
// ============================================================================
module alu_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_overflow,
  input  logic                  in_carryout,
  input  logic                  in_zero,
  input  logic [2:0]            in_aluop,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wen,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [3:0]            flags,
  input  logic                  flag_clr,
  output logic [CNT_W-1:0]      ovf_count,
  output logic                  trap
);

  // ALUop codes that matter for flag and overflow bookkeeping.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Bit positions inside a 4-bit {N,Z,C,V} flag vector.
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

  // Buffer occupancy doubles as the state of the stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t occ;
  occ_t occ_next;

  // Slot index of the oldest entry.
  logic head;
  logic wr_idx;
  logic push;
  logic pop;

  // Entry storage, one element per slot.
  logic [DATA_WIDTH-1:0] ent_result [2];
  logic [REG_ADDR_W-1:0] ent_dest   [2];
  logic [2:0]            ent_aluop  [2];
  logic [3:0]            ent_flags  [2];

  // Fields of the head entry.
  logic [2:0] head_aluop;
  logic [3:0] head_flags;
  logic       head_is_addsub;
  logic       ovf_event;
  logic       dest_nonzero;

  logic [3:0] flags_next;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // in_ready comes from the registered occupancy only, so there is no
  // combinational path from in_valid to in_ready. It is also forced low
  // while reset is asserted.
  assign in_ready  = resetn && (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Write slot
  // --------------------------------------------------------------------------
  // With one entry held, the free slot is the one not at head. That holds
  // even when the same edge also pops, because head then moves onto that
  // very slot.
  assign wr_idx = (occ == OCC_ONE) ? ~head : head;

  // --------------------------------------------------------------------------
  // Head entry fields
  // --------------------------------------------------------------------------
  assign out_wdata      = ent_result[head];
  assign out_dest       = ent_dest[head];
  assign head_aluop     = ent_aluop[head];
  assign head_flags     = ent_flags[head];
  assign head_is_addsub = (head_aluop == OP_ADD) || (head_aluop == OP_SUB);
  assign ovf_event      = pop && head_is_addsub && head_flags[FV];
  assign dest_nonzero   = (out_dest != '0);

  // --------------------------------------------------------------------------
  // Occupancy next-state
  // --------------------------------------------------------------------------
  // A full buffer cannot see a push, because in_ready is low when full.
  always_comb begin
    occ_next = occ;
    case (occ)
      OCC_EMPTY: begin
        if (push) occ_next = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && !pop)      occ_next = OCC_FULL;
        else if (!push && pop) occ_next = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) occ_next = OCC_ONE;
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Occupancy and head pointer registers
  // --------------------------------------------------------------------------
  // Reset throws away whatever was buffered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ  <= OCC_EMPTY;
      head <= 1'b0;
    end else begin
      occ <= occ_next;
      if (pop) head <= ~head;
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  // The payload needs no reset: it is only observed through out_valid.
  // N is taken from the result's sign bit. Z, C and V come straight from
  // the ALU.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_result[wr_idx] <= in_result;
      ent_dest[wr_idx]   <= in_dest;
      ent_aluop[wr_idx]  <= in_aluop;
      ent_flags[wr_idx]  <= {in_result[DATA_WIDTH-1], in_zero,
                             in_carryout, in_overflow};
    end
  end

  // --------------------------------------------------------------------------
  // Committed flag next-value
  // --------------------------------------------------------------------------
  // Which flags a commit loads depends on the ALUop class:
  //   - add/sub:  all four flags
  //   - and/or:   N and Z only
  //   - slt:      Z and V only
  //   - anything else leaves the flags alone
  // flag_clr wins over any same-cycle commit.
  always_comb begin
    flags_next = flags;
    if (flag_clr) begin
      flags_next = 4'b0000;
    end else if (pop) begin
      case (head_aluop)
        OP_ADD, OP_SUB: begin
          flags_next = head_flags;
        end
        OP_AND, OP_OR: begin
          flags_next[FN] = head_flags[FN];
          flags_next[FZ] = head_flags[FZ];
        end
        OP_SLT: begin
          flags_next[FZ] = head_flags[FZ];
          flags_next[FV] = head_flags[FV];
        end
        default: flags_next = flags;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Committed flags and overflow counter registers
  // --------------------------------------------------------------------------
  // The counter sticks at all-ones instead of wrapping. flag_clr does not
  // touch it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      flags     <= 4'b0000;
      ovf_count <= '0;
    end else begin
      flags <= flags_next;
      if (ovf_event && (ovf_count != {CNT_W{1'b1}})) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_RESULT_OVF_TRAP_EN
  // --------------------------------------------------------------------------
  // Overflow trap (feature enabled)
  // --------------------------------------------------------------------------
  // The trap is a registered pulse: it is high for exactly the cycle after
  // the commit of an overflowing add/sub. That entry's register write is
  // blocked while it sits at the head.
  logic trap_q;

  always_ff @(posedge clk) begin
    if (!resetn) trap_q <= 1'b0;
    else         trap_q <= ovf_event;
  end

  assign trap    = trap_q;
  assign out_wen = out_valid && dest_nonzero
                   && !(head_is_addsub && head_flags[FV]);
`else
  // --------------------------------------------------------------------------
  // Overflow trap (feature disabled)
  // --------------------------------------------------------------------------
  // No trap. Overflowing results are written like any other, and writes to
  // register 0 are dropped.
  assign trap    = 1'b0;
  assign out_wen = out_valid && dest_nonzero;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// tb_alu_result_stage
// ----------------------------------------------------------------------------
// Self-checking bench for alu_result_stage. It combines:
//   - a table of single-entry commit vectors with hand-computed
//     expectations, applied in a loop
//   - hand-written sequences for reset, backpressure, streaming, counter
//     saturation and reset in mid-operation
// Expectations that depend on ALU_RESULT_OVF_TRAP_EN follow the macro.
// ============================================================================
module tb_alu_result_stage;

`ifdef ALU_RESULT_OVF_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_carryout;
  logic        in_zero;
  logic [2:0]  in_aluop;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [4:0]  out_dest;
  logic [31:0] out_wdata;
  logic [3:0]  flags;
  logic        flag_clr;
  logic [7:0]  ovf_count;
  logic        trap;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  aluop;
    logic [4:0]  dest;
    logic        ovf;
    logic        cout;
    logic        zero;
    logic        clr;
    logic        exp_wen;
    logic [3:0]  exp_flags;
    logic [7:0]  exp_cnt;
    logic        exp_trap;
  } vec_t;

  vec_t vecs [10];

  alu_result_stage dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_overflow (in_overflow),
    .in_carryout (in_carryout),
    .in_zero     (in_zero),
    .in_aluop    (in_aluop),
    .in_dest     (in_dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wen     (out_wen),
    .out_dest    (out_dest),
    .out_wdata   (out_wdata),
    .flags       (flags),
    .flag_clr    (flag_clr),
    .ovf_count   (ovf_count),
    .trap        (trap)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and log any miss.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up the upstream payload (in_valid is driven separately).
  task automatic drivePayload(input logic [31:0] res, input logic [2:0] op,
                              input logic [4:0] dst, input logic v,
                              input logic c, input logic z);
    in_result   = res;
    in_aluop    = op;
    in_dest     = dst;
    in_overflow = v;
    in_carryout = c;
    in_zero     = z;
  endtask

  // Push one vector into an empty stage and check the head. Then pop it,
  // check the committed state, and check that any trap pulse has gone
  // one cycle later.
  task automatic applyStimulus(input int idx, input vec_t v);
    drivePayload(v.result, v.aluop, v.dest, v.ovf, v.cout, v.zero);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput($sformatf("vec%0d_out_valid", idx), out_valid, 1'b1);
    checkOutput($sformatf("vec%0d_out_wen", idx), out_wen, v.exp_wen);
    checkOutput($sformatf("vec%0d_out_wdata", idx), out_wdata, v.result);
    checkOutput($sformatf("vec%0d_out_dest", idx), out_dest, v.dest);
    out_ready = 1'b1;
    flag_clr  = v.clr;
    tick();
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    #1;
    checkOutput($sformatf("vec%0d_popped", idx), out_valid, 1'b0);
    checkOutput($sformatf("vec%0d_flags", idx), flags, v.exp_flags);
    checkOutput($sformatf("vec%0d_ovf_count", idx), ovf_count, v.exp_cnt);
    checkOutput($sformatf("vec%0d_trap", idx), trap, v.exp_trap);
    tick();
    checkOutput($sformatf("vec%0d_trap_gone", idx), trap, 1'b0);
  endtask

  initial begin
    // Vector table, applied in order starting from flags=0000, ovf_count=0.
    // Fields: result, aluop, dest, V, C, Z, clr | wen, flags, count, trap
    vecs[0] = '{32'h0000_0005, 3'b010, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0,
                1'b1,     4'b0000, 8'd0, 1'b0};
    vecs[1] = '{32'h0000_0000, 3'b110, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0,
                1'b1,     4'b0110, 8'd0, 1'b0};
    vecs[2] = '{32'h8000_0000, 3'b000, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0,
                1'b1,     4'b1010, 8'd0, 1'b0};
    vecs[3] = '{32'h0000_0000, 3'b111, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0,
                1'b1,     4'b1111, 8'd0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 3'b011, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0,
                1'b0,     4'b1111, 8'd0, 1'b0};
    vecs[5] = '{32'h0000_0001, 3'b001, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0,
                1'b1,     4'b0011, 8'd0, 1'b0};
    vecs[6] = '{32'h8000_0000, 3'b010, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0,
                !TRAP_ON, 4'b1001, 8'd1, TRAP_ON};
    vecs[7] = '{32'h0000_1234, 3'b110, 5'd9,  1'b0, 1'b1, 1'b0, 1'b1,
                1'b1,     4'b0000, 8'd1, 1'b0};
    vecs[8] = '{32'hFFFF_FFF0, 3'b110, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0,
                !TRAP_ON, 4'b1001, 8'd2, TRAP_ON};
    vecs[9] = '{32'h0000_0000, 3'b100, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1,     4'b1001, 8'd2, 1'b0};

    // Reset held for two cycles.
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    drivePayload(32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_flags", flags, 4'b0000);
    checkOutput("rst_ovf_count", ovf_count, 8'd0);
    checkOutput("rst_trap", trap, 1'b0);
    resetn = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1'b1);

    // Single-entry commit vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Backpressure: the third push waits upstream until space frees up.
    drivePayload(32'h11, 3'b100, 5'd1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1;
    checkOutput("bp_ready_a", in_ready, 1'b1);
    tick();
    in_result = 32'h22;
    #1;
    checkOutput("bp_ready_b", in_ready, 1'b1);
    tick();
    in_result = 32'h33;
    #1;
    checkOutput("bp_ready_c", in_ready, 1'b0);
    checkOutput("bp_head_c", out_wdata, 32'h11);
    tick();
    checkOutput("bp_ready_hold", in_ready, 1'b0);
    checkOutput("bp_head_hold", out_wdata, 32'h11);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_out1", out_wdata, 32'h11);
    tick();
    checkOutput("bp_ready_e", in_ready, 1'b1);
    checkOutput("bp_out2", out_wdata, 32'h22);
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("bp_out3", out_wdata, 32'h33);
    checkOutput("bp_valid3", out_valid, 1'b1);
    tick();
    checkOutput("bp_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Streaming: push and pop every cycle with one entry in flight.
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        drivePayload(32'h100 + i, 3'b100, 5'd1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkOutput($sformatf("st_ready%0d", i), in_ready, 1'b1);
      if (i > 0) begin
        checkOutput($sformatf("st_valid%0d", i), out_valid, 1'b1);
        checkOutput($sformatf("st_data%0d", i), out_wdata, 32'h100 + i - 1);
      end
      tick();
    end
    checkOutput("st_drained", out_valid, 1'b0);

    // Counter saturation: 300 overflowing adds on top of a count of 2.
    drivePayload(32'h8000_0000, 3'b010, 5'd2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) checkOutput("sat_mid", ovf_count, 8'd101);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("sat_count", ovf_count, 8'd255);
    checkOutput("sat_flags", flags, 4'b1001);
    checkOutput("sat_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    flag_clr  = 1'b1;
    tick();
    flag_clr = 1'b0;
    checkOutput("clr_flags", flags, 4'b0000);
    checkOutput("clr_keeps_count", ovf_count, 8'd255);

    // Reset while the buffer is full.
    drivePayload(32'hAA, 3'b010, 5'd3, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    checkOutput("mid_full_ready", in_ready, 1'b0);
    checkOutput("mid_full_valid", out_valid, 1'b1);
    resetn = 1'b0;
    tick();
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_ready", in_ready, 1'b0);
    checkOutput("mid_rst_count", ovf_count, 8'd0);
    resetn = 1'b1;
    tick();
    checkOutput("mid_rel_valid", out_valid, 1'b0);
    checkOutput("mid_rel_ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback stage that sits directly downstream of the 32-bit ALU.
- Registers each ALU result, together with its flags and destination register index, into a 2-entry skid buffer with a valid/ready handshake on both sides.
- On commit (pop) it updates an architectural status-flag register {N,Z,C,V} and a saturating overflow-event counter.
- Feeds the register-file write port.

Parameters:
- DATA_WIDTH, 32, datapath width of result and write data.
- REG_ADDR_W, 5, width of destination register index.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- resetn  in  1  synchronous reset, active-low
- in_valid  in  1  upstream has an ALU result this cycle
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_WIDTH  ALU Result
- in_overflow  in  1  ALU Overflow
- in_carryout  in  1  ALU CarryOut
- in_zero  in  1  ALU Zero
- in_aluop  in  3  ALUop that produced the result
- in_dest  in  REG_ADDR_W  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes head entry
- out_wen  out  1  register-file write enable for head entry
- out_dest  out  REG_ADDR_W  head destination index
- out_wdata  out  DATA_WIDTH  head result
- flags  out  4  committed {N,Z,C,V}
- flag_clr  in  1  clear committed flags
- ovf_count  out  CNT_W  committed add/sub overflow events, saturating
- trap  out  1  overflow trap pulse; tied 0 unless OVF_TRAP_EN is defined

Behaviour:
- Reset (resetn=0 at clk edge):
  - entry count=0, out_valid=0, flags=0, ovf_count=0, trap=0.
  - in_ready=0 while resetn=0; in_ready=1 on the first cycle after release.
  - Reset mid-operation discards all buffered entries.
- Accept: push when in_valid && in_ready. in_ready = (count<2), combinational from registered count.
- Commit: pop when out_valid && out_ready. out_valid = (count!=0).
- Data order: FIFO order. out_* always reflect the oldest entry and are held stable while out_valid && !out_ready.
- Latency: an entry accepted at edge k is visible on out_* after edge k (out_valid high in cycle k+1); no combinational in->out path.
- Count transitions:
  - count 0: push only -> 1.
  - count 1: push+pop -> 1; push only -> 2; pop only -> 0.
  - count 2: push impossible (in_ready=0); pop -> 1.
- Per-entry flags captured at push:
  - N = in_result[DATA_WIDTH-1]
  - Z = in_zero
  - C = in_carryout
  - V = in_overflow
- out_wen = out_valid && (out_dest != 0). Entries with dest 0 still pop but never write.
- Committed flag update on pop:
  - ALUop 010/110: all four flags loaded from the entry.
  - ALUop 000/001: N,Z loaded; C,V held.
  - ALUop 111: Z,V loaded; N,C held.
  - Other ALUop codes: no flag update.
- flag_clr has priority over a same-cycle pop update: flags become 0.
- ovf_count increments on pop of an ALUop 010/110 entry with V=1; saturates at all-ones, no wrap. It is not cleared by flag_clr.

Optional Feature:
- Macro: ALU_RESULT_OVF_TRAP_EN.
- Defined:
  - On pop of an ALUop 010/110 entry with V=1, trap=1 for exactly that one cycle (registered, visible the cycle after the pop edge).
  - out_wen for that entry is forced 0, so no register write occurs.
  - Flags and ovf_count still update.
- Undefined: trap tied 0; overflowing results are written normally.

Test Plan:
- Reset then single push: resetn low 2 cycles; push result=0x0000_0005, dest=3, aluop=010, out_ready=1 -> out_valid in next cycle, out_wen=1, out_wdata=5; after pop, flags=0000.
- Backpressure: out_ready=0, push 3 entries on consecutive cycles (0x11, 0x22, 0x33) -> in_ready drops after the 2nd accept, 3rd is held upstream. Release out_ready -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
- Simultaneous push/pop at count 1: continuous valid stream of 10 results, out_ready=1 -> one commit per cycle, count stays 1, in_ready never drops.
- Flag rules: commit sub (aluop=110) with result 0, Z=1, C=1 -> flags=0110. Then commit and (aluop=000) with result 0x8000_0000, Z=0 -> flags=1010 (C held). Assert flag_clr together with a pop -> flags=0000.
- Overflow and dest 0: commit 300 add entries with V=1 -> ovf_count saturates at 255. Commit entry with dest=0 -> out_wen=0, pop still occurs.
- With ALU_RESULT_OVF_TRAP_EN defined: commit add 0x7FFF_FFFF+1 (V=1), dest=4 -> trap one-cycle pulse, out_wen=0, flags V=1. Without the macro -> trap=0, out_wen=1.
